// File: rtl/brisc_pkg.sv
// Shared definitions for the brisc memory subsystem.
// Provides port indices, arbiter FSM encodings, bus widths and the access-legality check.
package brisc_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_D  = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic port;
      logic err;
      logic was_write;
   } resp_t;

   // An access is illegal when it is misaligned or its word would extend past the RAM.
   function automatic logic access_err(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] limit);
      return (addr[1:0] != 2'b00) || (addr > limit);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins at once, and on a tie
// the port that did not win last time gets the grant.
module rr_arb2
   import brisc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       sel
);

   logic last;

   always_comb begin
      gnt = 2'b00;
      sel = PORT_IF;
      if (rst_n) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == PORT_D) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
         sel = gnt[1] ? PORT_D : PORT_IF;
      end
   end

   // Reset leaves the pointer on the data port so fetch wins the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last <= PORT_D;
      end else if (|gnt) begin
         last <= sel;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a read-only fetch port and a read/write data port onto one
// single-ported RAM with registered read data, one grant per cycle.
module mem_arbiter
   import brisc_pkg::*;
#(
   parameter int SZ = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic              if_err,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic              d_err,
   output logic [DATA_W-1:0] d_rdata,
   output logic              ram_w_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out
);

   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(SZ - 4);

   logic [1:0]  gnt;
   logic        sel;
   logic        any_gnt;
   logic        cur_err;
   logic        cur_write;
   arb_state_t  state;
   arb_state_t  state_next;
   resp_t       resp;
   resp_t       resp_next;

   rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({d_req, if_req}),
      .gnt   (gnt),
      .sel   (sel)
   );

   assign if_gnt  = gnt[0];
   assign d_gnt   = gnt[1];
   assign any_gnt = |gnt;

   // Drive the winning access straight onto the RAM; errors never write.
   always_comb begin
      ram_addr    = (sel == PORT_D) ? d_addr : if_addr;
      ram_data_in = d_wdata;
      cur_err     = access_err(ram_addr, LIMIT);
      cur_write   = (sel == PORT_D) && d_we;
      ram_w_en    = any_gnt && cur_write && !cur_err;
   end

   always_comb begin
      state_next = state;
      resp_next  = resp;
      unique case (state)
         ST_IDLE: if (any_gnt) state_next = ST_RESP;
         ST_RESP: if (!any_gnt) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (any_gnt) begin
         resp_next.port      = sel;
         resp_next.err       = cur_err;
         resp_next.was_write = cur_write;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         resp  <= '0;
      end else begin
         state <= state_next;
         resp  <= resp_next;
      end
   end

   // Response outputs are gated by reset so a pending response is never seen.
   always_comb begin
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      if_err    = 1'b0;
      d_err     = 1'b0;
      if_rdata  = '0;
      d_rdata   = '0;
      if (rst_n && state == ST_RESP) begin
         if (resp.port == PORT_IF) begin
            if_rvalid = 1'b1;
            if_err    = resp.err;
            if (!resp.err && !resp.was_write) if_rdata = ram_data_out;
         end else begin
            d_rvalid = 1'b1;
            d_err    = resp.err;
            if (!resp.err && !resp.was_write) d_rdata = ram_data_out;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural registered-read RAM.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic        d_gnt, d_rvalid, d_err;
   logic [31:0] d_rdata;
   logic        ram_w_en;
   logic [31:0] ram_addr, ram_data_in, ram_data_out;

   logic [31:0] mem [0:1023];
   int errors;
   int checks;

   mem_arbiter #(.SZ(4096)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_gnt       (if_gnt),
      .if_rvalid    (if_rvalid),
      .if_err       (if_err),
      .if_rdata     (if_rdata),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_gnt        (d_gnt),
      .d_rvalid     (d_rvalid),
      .d_err        (d_err),
      .d_rdata      (d_rdata),
      .ram_w_en     (ram_w_en),
      .ram_addr     (ram_addr),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (ram_w_en) mem[ram_addr[11:2]] <= ram_data_in;
      ram_data_out <= mem[ram_addr[11:2]];
   end

   task automatic idle_inputs();
      if_req  = 1'b0;
      if_addr = 32'h0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = 32'h0;
      d_wdata = 32'h0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      if_req = 1'b1;
      d_req  = 1'b1;
      d_we   = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({if_gnt, d_gnt, ram_w_en} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_gnt: got if_gnt/d_gnt/w_en=%b required 000", {if_gnt, d_gnt, ram_w_en});
      end
      checks++;
      if ({if_rvalid, d_rvalid, if_err, d_err} !== 4'b0000 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_resp: got rv=%b%b err=%b%b rdata=%h/%h required all 0",
                  if_rvalid, d_rvalid, if_err, d_err, if_rdata, d_rdata);
      end
      idle_inputs();
      rst_n = 1'b1;
   endtask

   task automatic test_lone_fetch();
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'h0050_0093;
      #1;
      checks++;
      if (d_gnt !== 1'b1 || ram_w_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fetch_setup_write: got d_gnt=%b w_en=%b required 1 1", d_gnt, ram_w_en);
      end
      @(negedge clk);
      idle_inputs();
      if_req = 1'b1; if_addr = 32'h0;
      #1;
      checks++;
      if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || if_gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fetch_gnt: got d_rvalid=%b d_rdata=%h if_gnt=%b required 1 0 1", d_rvalid, d_rdata, if_gnt);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (if_rvalid !== 1'b1 || if_err !== 1'b0 || if_rdata !== 32'h0050_0093) begin
         errors++;
         $display("[TB] FAIL fetch_resp: got rvalid=%b err=%b rdata=%h required 1 0 00500093", if_rvalid, if_err, if_rdata);
      end
   endtask

   task automatic test_contention();
      logic exp_if;
      do_reset();
      if_req = 1'b1; if_addr = 32'h0;
      d_req  = 1'b1; d_addr  = 32'h0;
      for (int i = 0; i < 4; i++) begin
         exp_if = (i % 2 == 0);
         #1;
         checks++;
         if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
            errors++;
            $display("[TB] FAIL contention_gnt%0d: got if/d=%b%b required %b%b", i, if_gnt, d_gnt, exp_if, !exp_if);
         end
         if (i > 0) begin
            checks++;
            if (if_rvalid !== !exp_if || d_rvalid !== exp_if ||
                (exp_if ? d_rdata : if_rdata) !== 32'h0050_0093) begin
               errors++;
               $display("[TB] FAIL contention_resp%0d: got if/d rvalid=%b%b rdata=%h/%h required %b%b 00500093",
                        i, if_rvalid, d_rvalid, if_rdata, d_rdata, !exp_if, exp_if);
            end
         end
         @(negedge clk);
      end
      idle_inputs();
      #1;
      checks++;
      if (if_rvalid !== 1'b0 || d_rvalid !== 1'b1 || d_rdata !== 32'h0050_0093) begin
         errors++;
         $display("[TB] FAIL contention_last: got if/d rvalid=%b%b d_rdata=%h required 01 00500093", if_rvalid, d_rvalid, d_rdata);
      end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (ram_w_en !== 1'b1 || ram_addr !== 32'h10 || ram_data_in !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL wr_ram: got w_en=%b addr=%h din=%h required 1 10 deadbeef", ram_w_en, ram_addr, ram_data_in);
      end
      @(negedge clk);
      d_we = 1'b0; d_wdata = 32'h0;
      #1;
      checks++;
      if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_gnt !== 1'b1 || ram_w_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wr_resp: got rvalid=%b rdata=%h gnt=%b w_en=%b required 1 0 1 0", d_rvalid, d_rdata, d_gnt, ram_w_en);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (d_rvalid !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL rd_after_wr: got rvalid=%b err=%b rdata=%h required 1 0 deadbeef", d_rvalid, d_err, d_rdata);
      end
   endtask

   task automatic test_errors();
      @(negedge clk);
      d_req = 1'b1; d_addr = 32'h2;
      #1;
      checks++;
      if (d_gnt !== 1'b1 || ram_w_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_misalign_gnt: got gnt=%b w_en=%b required 1 0", d_gnt, ram_w_en);
      end
      @(negedge clk);
      idle_inputs();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'd4096; d_wdata = 32'hBAD0_BAD0;
      #1;
      checks++;
      if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0 || ram_w_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_misalign_resp: got rvalid=%b err=%b rdata=%h w_en=%b required 1 1 0 0",
                  d_rvalid, d_err, d_rdata, ram_w_en);
      end
      @(negedge clk);
      idle_inputs();
      if_req = 1'b1; if_addr = 32'd4096;
      #1;
      checks++;
      if (d_err !== 1'b1 || if_gnt !== 1'b1 || ram_w_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_oor_write: got d_err=%b if_gnt=%b w_en=%b required 1 1 0", d_err, if_gnt, ram_w_en);
      end
      @(negedge clk);
      if_addr = 32'd4092;
      #1;
      checks++;
      if (if_rvalid !== 1'b1 || if_err !== 1'b1 || if_rdata !== 32'h0 || ram_w_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_oor_fetch: got rvalid=%b err=%b rdata=%h w_en=%b required 1 1 0 0",
                  if_rvalid, if_err, if_rdata, ram_w_en);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (if_rvalid !== 1'b1 || if_err !== 1'b0 || d_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_boundary_ok: got rvalid=%b if_err=%b d_err=%b required 1 0 0", if_rvalid, if_err, d_err);
      end
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0;
      #1;
      checks++;
      if (if_gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_gnt: got if_gnt=%b required 1", if_gnt);
      end
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      #1;
      checks++;
      if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midrst_in_reset: got rvalid if/d=%b%b rdata=%h required 00 0", if_rvalid, d_rvalid, if_rdata);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      if_req = 1'b1; if_addr = 32'h0;
      d_req  = 1'b1; d_addr  = 32'h10;
      #1;
      checks++;
      if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_discard: got rvalid if/d=%b%b required 00", if_rvalid, d_rvalid);
      end
      checks++;
      if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_tie: got if/d gnt=%b%b required 10", if_gnt, d_gnt);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== 32'h0050_0093) begin
         errors++;
         $display("[TB] FAIL midrst_resp: got rvalid if/d=%b%b rdata=%h required 10 00500093", if_rvalid, d_rvalid, if_rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] wr_data [0:1];
      logic [31:0] rd_data [0:2];
      wr_data[0] = 32'h1111_1111;
      wr_data[1] = 32'h2222_2222;
      rd_data[0] = 32'h0050_0093;
      rd_data[1] = 32'h1111_1111;
      rd_data[2] = 32'h2222_2222;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         d_req = 1'b1; d_we = 1'b1; d_addr = 32'(4 * (i + 1)); d_wdata = wr_data[i];
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         d_req = 1'b1; d_we = 1'b0; d_wdata = 32'h0; d_addr = 32'(4 * i);
         #1;
         checks++;
         if (d_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_gnt%0d: got d_gnt=%b required 1", i, d_gnt);
         end
         if (i > 0) begin
            checks++;
            if (d_rvalid !== 1'b1 || d_rdata !== rd_data[i-1]) begin
               errors++;
               $display("[TB] FAIL b2b_resp%0d: got rvalid=%b rdata=%h required 1 %h", i - 1, d_rvalid, d_rdata, rd_data[i-1]);
            end
         end
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (d_rvalid !== 1'b1 || d_rdata !== rd_data[2]) begin
         errors++;
         $display("[TB] FAIL b2b_resp2: got rvalid=%b rdata=%h required 1 %h", d_rvalid, d_rdata, rd_data[2]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL b2b_end: got rvalid=%b rdata=%h required 0 0", d_rvalid, d_rdata);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_lone_fetch();
      test_contention();
      test_write_read();
      test_errors();
      test_reset_midop();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter SZ, default 4096, RAM size in bytes; this is the range limit for access checks.
REQ-002 SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port if_req, input, 1, fetch port request (read-only).
REQ-005 SHALL have port if_addr, input, 32, fetch byte address.
REQ-006 SHALL have port if_gnt, output, 1, fetch request accepted this cycle.
REQ-007 SHALL have ports if_rvalid, if_err, output, 1 each, fetch response valid and fetch error.
REQ-008 SHALL have port if_rdata, output, 32, fetch read data.
REQ-009 SHALL have ports d_req, d_we, input, 1 each, data port request and write enable.
REQ-010 SHALL have ports d_addr, d_wdata, input, 32 each, data address and write data.
REQ-011 SHALL have ports d_gnt, d_rvalid, d_err, output, 1 each, data grant, response valid and error.
REQ-012 SHALL have port d_rdata, output, 32, data read data.
REQ-013 SHALL have ports ram_w_en, output, 1, and ram_addr, ram_data_in, output, 32 each, driving the RAM block.
REQ-014 SHALL have port ram_data_out, input, 32, RAM registered read data, valid one cycle after its address.

Function
REQ-015 SHALL grant at most one request per cycle; the grant is combinational from req and the round-robin pointer.
REQ-016 SHALL grant a sole requester immediately; when both request, the port not granted last SHALL win.
REQ-017 SHALL update the last-grant pointer only on a cycle with a grant.
REQ-018 SHALL require each requester to hold req, addr, we and wdata stable until gnt; an ungranted port sees no effect.
REQ-019 SHALL flag an access as an error if addr[1:0] != 0 or addr > SZ-4.
REQ-020 SHALL drive a granted, legal access to the RAM in the same cycle: ram_addr = addr, ram_w_en = d_we for the data port (0 for fetch), ram_data_in = d_wdata.
REQ-021 SHALL hold ram_w_en at 0 when there is no grant or the granted access is an error.
REQ-022 SHALL give every grant exactly one response: one-cycle rvalid on the granting port in cycle N+1.
REQ-023 SHALL register the response state (valid, port, err, was_write) at the grant edge; the FSM states are IDLE (no response pending) and RESP (response pending next cycle).
REQ-024 SHALL go from IDLE to RESP on a grant, stay in RESP on a grant in RESP, and go from RESP to IDLE when there is no grant.
REQ-025 SHALL pipeline grants back-to-back, one per cycle, with full throughput and no bubbles.
REQ-026 SHALL drive rdata = ram_data_out for a legal read response; for write or error responses rdata SHALL be 0.
REQ-027 SHALL assert err with rvalid for an error response and perform no RAM access for it.
REQ-028 SHALL drive rdata = 0 and err = 0 on a port whenever its rvalid is 0.
REQ-029 SHALL give a read to an address written the previous cycle the new data; no forwarding is needed because accesses are serialised.

Reset
REQ-030 SHALL, while rst_n = 0 at a clock edge, set state IDLE and last-grant = data port, so fetch wins the first tie.
REQ-031 SHALL, while rst_n = 0, force all gnt, rvalid, err and ram_w_en low and rdata = 0.
REQ-032 SHALL, on reset in RESP, discard the pending response and never deliver it.

Structure
REQ-033 SHALL take from shared package brisc_pkg the port index constants (PORT_IF = 0, PORT_D = 1), the FSM state encodings, and ADDR_W = DATA_W = 32.
REQ-034 SHALL place the two-way round-robin grant and pointer in one sub-module, rr_arb2.

Verification
REQ-035 SHALL verify a lone fetch read: write 0x00500093 at address 0 via the data port, then if_req at address 0 -> if_gnt in cycle N, if_rvalid and if_rdata = 0x00500093 in N+1.
REQ-036 SHALL verify contention: both ports request continuously for 4 cycles after reset -> grant order IF, D, IF, D, with responses in the same order one cycle later.
REQ-037 SHALL verify write-then-read: d_we write 0xDEADBEEF to 0x10, then d read 0x10 in the next cycle -> d_rdata = 0xDEADBEEF, with the write response rdata = 0.
REQ-038 SHALL verify errors: d read at 0x2 -> d_err = 1 with rvalid; fetch at SZ (4096) -> if_err = 1; ram_w_en stays 0 throughout.
REQ-039 SHALL verify reset mid-operation: rst_n = 0 in the cycle after a grant -> no rvalid on either port, and fetch wins the first tie after release.
REQ-040 SHALL verify a back-to-back data stream: reads of 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive d_rvalid pulses with matching data.
